// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  localparam int NIB_BITS = 4;

  // Width of the nibble index; kept at least 1 bit so the index is never zero-width.
  function automatic int idx_w(input int nib);
    if (nib <= 1) begin
      return 1;
    end else begin
      return $clog2(nib);
    end
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with full lookahead carries C1..C4.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

// File: rtl/cla_seq.sv
// Wide add performed one nibble per clock on a single cla4_slice, carry chained in a register.
// Optional subtract support is compiled in with CLA_SEQ_SUB_EN.
module cla_seq
  import cla_seq_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NIB_BITS*NIB-1:0] a,
  input  logic [NIB_BITS*NIB-1:0] b,
  input  logic                    cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [NIB_BITS*NIB-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W  = NIB_BITS * NIB;
  localparam int IW = idx_w(NIB);

  cla_seq_state_t r_state;
  cla_seq_state_t w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;

  logic [W-1:0]  w_beff;
  logic          w_cin_eff;
  logic [3:0]    w_na;
  logic [3:0]    w_nb;
  logic [3:0]    w_s;
  logic          w_sc;
  logic          w_last;

`ifdef CLA_SEQ_SUB_EN
  logic r_sub;
  assign w_beff    = r_sub ? ~r_b : r_b;
  assign w_cin_eff = sub ? 1'b1 : cin;
`else
  assign w_beff    = r_b;
  assign w_cin_eff = cin;
`endif

  assign w_na   = r_a[{r_idx, 2'b00} +: NIB_BITS];
  assign w_nb   = w_beff[{r_idx, 2'b00} +: NIB_BITS];
  assign w_last = (r_idx == IW'(NIB - 1));

  cla4_slice u_slice (
    .a    (w_na),
    .b    (w_nb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_sc)
  );

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Operand capture, nibble-serial accumulation and final flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= w_cin_eff;
`ifdef CLA_SEQ_SUB_EN
            r_sub   <= sub;
`endif
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: NIB_BITS] <= w_s;
          r_carry <= w_sc;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout <= w_sc;
            // Signed overflow: same-sign operands producing a result of the other sign.
            r_ovf  <= (r_a[W-1] == w_beff[W-1]) && (w_s[3] != r_a[W-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq.sv
// Self-checking bench for cla_seq: cycle-level behavioural model, per-cycle compare, directed and random ops.
module tb_cla_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic         ovf;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_seq #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t = -1 when idle, else edges elapsed since the accepted start.
  int           m_t = -1;
  logic [W-1:0] m_sum = '0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_rcout = 1'b0, m_rovf = 1'b0;
  logic [63:0]  m_full;
  logic [W-1:0] m_binv;
  longint       m_sv;
  logic         m_sub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
`ifdef CLA_SEQ_SUB_EN
        m_sub = sub;
`else
        m_sub = 1'b0;
`endif
        m_binv = ~b;
        if (m_sub) begin
          m_full = 64'(a) + 64'(m_binv) + 64'd1;
          m_sv   = longint'($signed(a)) - longint'($signed(b));
        end else begin
          m_full = 64'(a) + 64'(b) + 64'(cin);
          m_sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        m_res   = m_full[W-1:0];
        m_rcout = m_full[W];
        m_rovf  = (m_sv > (64'sd1 <<< (W-1)) - 1) || (m_sv < -(64'sd1 <<< (W-1)));
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == NIB) begin
        m_sum = m_res; m_cout = m_rcout; m_ovf = m_rovf;
      end else if (m_t > NIB) begin
        m_t = -1;
      end
    end
  end

  logic [63:0]  c_mask;
  logic [W-1:0] c_sum;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_t >= 1 && m_t < NIB) begin
        c_mask = (64'd1 << (4 * m_t)) - 64'd1;
        c_sum  = (m_sum & ~c_mask[W-1:0]) | (m_res & c_mask[W-1:0]);
      end else begin
        c_sum = m_sum;
      end
      chk("busy", 64'(busy), 64'(m_t >= 0 && m_t < NIB));
      chk("done", 64'(done), 64'(m_t == NIB));
      chk("sum",  64'(sum),  64'(c_sum));
      chk("cout", 64'(cout), 64'(m_cout));
      chk("ovf",  64'(ovf),  64'(m_ovf));
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * NIB + 4; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic lit(input string nm, input logic [W-1:0] es, input logic ec, input logic eo);
    chk({nm, "_sum"},  64'(sum),  64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"},  64'(ovf),  64'(eo));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    lit("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done();
    lit("add1", 16'h5555, 1'b0, 1'b0);
    @(negedge clk);

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done();
    lit("ripple", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    wait_done();
    lit("ovf", 16'h8000, 1'b0, 1'b1);
    // start coincident with done must be ignored
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", 64'(busy), 64'd0);

`ifdef CLA_SEQ_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done();
    lit("sub", 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
`endif

    // Second start mid-run with new operands is ignored.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_busy", 64'(busy), 64'd1);
    wait_done();
    lit("ignored", 16'h5555, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset at edge 2 of an operation.
    issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    lit("arst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done();
    lit("post_rst", 16'h0000, 1'b1, 1'b1);
    @(negedge clk);

    // Random operations with spurious starts and operand churn while running.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0) ra = W'(16'h7FFF) ^ W'($urandom_range(0, 1) << (W - 1));
      if ($urandom_range(0, 4) == 0) rb = ~ra;
      issue(ra, rb, 1'($urandom), 1'($urandom));
      for (int j = 0; j < NIB - 1; j++) begin
        start = 1'($urandom);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      wait_done();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
